int_dispatch: RTL and testbench
===============================

Name: int_dispatch

Overview:
- Issue-side partner of the integer reservation station / ALU unit.
- Accepts one decoded integer instruction at a time and renames its sources through a register status table.
- Resolves source operands from the register file, the ROB or the CDB, then drives the 76-bit `rs_data` packet with a one-cycle `rs_dest` strobe into the reservation station.
- Allocates the destination ROB tag and tracks ownership of architectural registers until commit.

Parameters:
- XLEN, 32, operand width.
- TAG_W, 6, ROB tag width. Tag 0 is reserved and means "no broadcast" on the CDB.
- NREG, 32, number of architectural registers. x0 is hardwired to zero.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- dec_valid  in  1  decoded instruction present
- dec_ready  out  1  dispatcher accepts this cycle
- dec_aluop  in  4  ALU opcode, passed through unchanged
- dec_rd, dec_rs1, dec_rs2  in  5 each  architectural register indices
- dec_use_imm  in  1  operand2 comes from dec_imm
- dec_imm  in  XLEN  sign-extended immediate
- rf_raddr1, rf_raddr2  out  5 each  register file read addresses (= dec_rs1/dec_rs2)
- rf_rdata1, rf_rdata2  in  XLEN each  combinational register file data
- rob_full  in  1  ROB cannot allocate
- rob_alloc  out  1  allocate pulse (= dec_valid && dec_ready)
- rob_alloc_tag  in  TAG_W  tag ROB grants on allocation (never 0)
- rob_rtag1, rob_rtag2  out  TAG_W each  ROB value lookup tags
- rob_rready1, rob_rready2  in  1 each  ROB entry already holds result
- rob_rdata1, rob_rdata2  in  XLEN each  ROB entry result
- cdb_data  in  TAG_W+XLEN  {tag, value}; tag 0 = idle
- commit_valid  in  1  ROB retires an instruction
- commit_rd  in  5  retiring destination register
- commit_tag  in  TAG_W  retiring tag
- rs_is_full  in  1  reservation station has no free entry
- rs_dest  out  1  packet write strobe
- rs_data  out  76  {aluop[4], rob_dest[TAG_W], valid1, operand1[XLEN], valid2, operand2[XLEN]}

Behaviour:
- Reset (reset==0 at posedge):
  - All status-table busy bits cleared.
  - rs_dest=0, output packet register zeroed, so rs_data=0.
- Handshake:
  - `dec_ready = reset && !rs_is_full && !rob_full && !rs_dest`.
  - One cycle is forced idle after each send, because rs_is_full reflects a send only two cycles later; this guarantees no packet is dropped by a full station.
- Accept (dec_valid && dec_ready) in cycle N:
  - Packet is registered at the edge ending N.
  - rs_dest=1 for exactly cycle N+1.
  - Latency decode→RS write is 1 cycle.
- Source resolution, per operand, evaluated in cycle N, in priority order:
  1. rs==0 → value 0, valid.
  2. Table entry not busy → rf_rdata, valid.
  3. Busy and cdb tag (nonzero) == entry tag → cdb value, valid.
  4. Busy and rob_rready → rob_rdata, valid.
  5. Otherwise → invalid; the operand field carries the entry tag zero-extended to XLEN.
  - `dec_use_imm` overrides operand2 with dec_imm, valid.
- Output forwarding in cycle N+1:
  - If a registered operand is invalid and cdb tag (nonzero) equals its low TAG_W bits, rs_data presents the CDB value with valid=1.
  - This is a combinational override so the reservation station never misses a broadcast during its write cycle.
- rob_rtag1/2 = table tag of rs1/rs2 (don't-care when not busy).
- Status table:
  - On accept with dec_rd != 0: entry[rd] ← {busy=1, tag=rob_alloc_tag}.
  - On commit_valid: if entry[commit_rd] is busy and its tag == commit_tag, clear busy; otherwise no effect (a younger writer owns it).
  - Accept and commit to the same rd in one cycle: the accept write wins.
  - An accept whose rd equals its own rs1/rs2 reads the pre-update entry.
- dec_rd == 0: a tag is still allocated, but the table is unchanged.
- When rs_dest=0, rs_data holds the last packet; the station ignores it.
- Reset asserted mid-operation: any pending packet is discarded, rs_dest is forced 0, and the table is cleared.

Test Plan:
- Reset, then dec x5=x1+x2 with rf x1=7, x2=9, tag 3 → next cycle rs_dest=1, rs_data={0000,3,1,7,1,9}.
- Back-to-back: dec_valid held high for 2 instructions → dec_ready pattern 1,0,1; rs_dest pulses in cycles 1 and 3.
- RAW hazard: x5 ← tag 3, then x6=x5+x1 with ROB not ready and idle CDB → valid1=0, operand1=3; entry[6] busy with tag 4.
- CDB bypass: same as the previous scenario, but cdb_data={3,42} during resolve → valid1=1, operand1=42. Repeat with the CDB arriving in the rs_dest cycle → rs_data shows valid1=1, 42.
- Commit: x5 tag 3, then x5 tag 8, then commit {x5, tag 3} → x5 stays busy with tag 8. Commit {x5, tag 8} → the next read of x5 uses rf.
- Backpressure: rs_is_full=1 or rob_full=1 → dec_ready=0, rob_alloc=0, rs_dest stays 0, table unchanged. Assert reset during an rs_dest cycle → rs_dest=0 next cycle.

Source files
------------

// File: rtl/int_dispatch.sv
// int_dispatch: integer issue/dispatch stage feeding the integer reservation station.
// Renames sources through a register status table, resolves operands from the
// register file / ROB / CDB, allocates the destination ROB tag and emits a
// registered packet with a one-cycle rs_dest strobe.
// Ports:
//   clk, reset (sync, active-low)
//   dec_*          decoded instruction in, dec_ready handshake out
//   rf_raddr*/rf_rdata*   register file read (combinational)
//   rob_full, rob_alloc, rob_alloc_tag   ROB allocation
//   rob_rtag*/rob_rready*/rob_rdata*     ROB value lookup
//   cdb_data       {tag, value}, tag 0 = idle
//   commit_*       ROB retirement
//   rs_is_full, rs_dest, rs_data         reservation station write port
module int_dispatch #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned NREG  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dec_valid,
  output logic                      dec_ready,
  input  logic [3:0]                dec_aluop,
  input  logic [4:0]                dec_rd,
  input  logic [4:0]                dec_rs1,
  input  logic [4:0]                dec_rs2,
  input  logic                      dec_use_imm,
  input  logic [XLEN-1:0]           dec_imm,
  output logic [4:0]                rf_raddr1,
  output logic [4:0]                rf_raddr2,
  input  logic [XLEN-1:0]           rf_rdata1,
  input  logic [XLEN-1:0]           rf_rdata2,
  input  logic                      rob_full,
  output logic                      rob_alloc,
  input  logic [TAG_W-1:0]          rob_alloc_tag,
  output logic [TAG_W-1:0]          rob_rtag1,
  output logic [TAG_W-1:0]          rob_rtag2,
  input  logic                      rob_rready1,
  input  logic                      rob_rready2,
  input  logic [XLEN-1:0]           rob_rdata1,
  input  logic [XLEN-1:0]           rob_rdata2,
  input  logic [TAG_W+XLEN-1:0]     cdb_data,
  input  logic                      commit_valid,
  input  logic [4:0]                commit_rd,
  input  logic [TAG_W-1:0]          commit_tag,
  input  logic                      rs_is_full,
  output logic                      rs_dest,
  output logic [4+TAG_W+2*XLEN+1:0] rs_data
);

  localparam int unsigned PKT_W = 4 + TAG_W + 2 * XLEN + 2;
  localparam int unsigned V1    = 2 * XLEN + 1;  // valid1 bit
  localparam int unsigned O1    = XLEN + 1;      // operand1 lsb
  localparam int unsigned V2    = XLEN;          // valid2 bit

  logic [NREG-1:0]  busy_q, busy_d;
  logic [TAG_W-1:0] tag_q [NREG];
  logic [TAG_W-1:0] tag_d [NREG];
  logic             rs_dest_q, rs_dest_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;

  logic             accept;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_val;
  logic [XLEN:0]    src1, src2, op2;

  assign cdb_tag = cdb_data[TAG_W+XLEN-1:XLEN];
  assign cdb_val = cdb_data[XLEN-1:0];

  // rs_dest_q in the term keeps a bubble after every send: rs_is_full lags
  // a send by two cycles, so this is what prevents overrunning the station.
  assign dec_ready = reset && !rs_is_full && !rob_full && !rs_dest_q;
  assign accept    = dec_valid && dec_ready;
  assign rob_alloc = accept;
  assign rf_raddr1 = dec_rs1;
  assign rf_raddr2 = dec_rs2;
  assign rob_rtag1 = tag_q[dec_rs1];
  assign rob_rtag2 = tag_q[dec_rs2];
  assign rs_dest   = rs_dest_q;

  // Returns {valid, value}; unresolved operands carry the producer tag.
  function automatic logic [XLEN:0] resolve(
    input logic [4:0]       rs,
    input logic             busy,
    input logic [TAG_W-1:0] tag,
    input logic [XLEN-1:0]  rf,
    input logic             rrdy,
    input logic [XLEN-1:0]  rdata,
    input logic [TAG_W-1:0] ctag,
    input logic [XLEN-1:0]  cval
  );
    if (rs == 5'd0)                        return {1'b1, XLEN'(0)};
    else if (!busy)                        return {1'b1, rf};
    else if (ctag != '0 && ctag == tag)    return {1'b1, cval};
    else if (rrdy)                         return {1'b1, rdata};
    else                                   return {1'b0, XLEN'(tag)};
  endfunction

  always_comb begin
    src1 = resolve(dec_rs1, busy_q[dec_rs1], tag_q[dec_rs1], rf_rdata1,
                   rob_rready1, rob_rdata1, cdb_tag, cdb_val);
    src2 = resolve(dec_rs2, busy_q[dec_rs2], tag_q[dec_rs2], rf_rdata2,
                   rob_rready2, rob_rdata2, cdb_tag, cdb_val);
    op2  = dec_use_imm ? {1'b1, dec_imm} : src2;
  end

  always_comb begin
    busy_d    = busy_q;
    tag_d     = tag_q;
    pkt_d     = pkt_q;
    rs_dest_d = accept;
    // Commit only releases a register still owned by the retiring tag.
    if (commit_valid && busy_q[commit_rd] && tag_q[commit_rd] == commit_tag)
      busy_d[commit_rd] = 1'b0;
    // Applied after commit so a same-cycle accept to the same rd wins.
    if (accept) begin
      pkt_d = {dec_aluop, rob_alloc_tag, src1, op2};
      if (dec_rd != 5'd0) begin
        busy_d[dec_rd] = 1'b1;
        tag_d[dec_rd]  = rob_alloc_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q    <= '0;
      rs_dest_q <= 1'b0;
      pkt_q     <= '0;
      for (int unsigned i = 0; i < NREG; i++) tag_q[i] <= '0;
    end else begin
      busy_q    <= busy_d;
      tag_q     <= tag_d;
      rs_dest_q <= rs_dest_d;
      pkt_q     <= pkt_d;
    end
  end

  // Late CDB broadcast during the write cycle is folded into the packet so
  // the station cannot miss it; the held packet is left untouched otherwise.
  always_comb begin
    rs_data = pkt_q;
    if (rs_dest_q && cdb_tag != '0) begin
      if (!pkt_q[V1] && pkt_q[O1 +: TAG_W] == cdb_tag) begin
        rs_data[V1]          = 1'b1;
        rs_data[O1 +: XLEN]  = cdb_val;
      end
      if (!pkt_q[V2] && pkt_q[TAG_W-1:0] == cdb_tag) begin
        rs_data[V2]          = 1'b1;
        rs_data[XLEN-1:0]    = cdb_val;
      end
    end
  end

endmodule

// File: tb/tb_int_dispatch.sv
// Self-checking bench for int_dispatch: table-driven single sends, hand
// sequences for hazards/commit/backpressure/reset, then randomized traffic
// against an ownership-map reference model.
module tb_int_dispatch;

  logic        clk, reset;
  logic        dec_valid, dec_ready;
  logic [3:0]  dec_aluop;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic        dec_use_imm;
  logic [31:0] dec_imm;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        rob_full, rob_alloc;
  logic [5:0]  rob_alloc_tag, rob_rtag1, rob_rtag2;
  logic        rob_rready1, rob_rready2;
  logic [31:0] rob_rdata1, rob_rdata2;
  logic [37:0] cdb_data;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [5:0]  commit_tag;
  logic        rs_is_full, rs_dest;
  logic [75:0] rs_data;

  logic [31:0] rf_mem [32];
  logic        rob_rdy_mem [64];
  logic [31:0] rob_val_mem [64];
  int          ref_owner [32];   // 0 = register free, else owning ROB tag

  int n_cmp, n_fail;

  int_dispatch dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_aluop(dec_aluop),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_imm(dec_use_imm), .dec_imm(dec_imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rob_full(rob_full), .rob_alloc(rob_alloc), .rob_alloc_tag(rob_alloc_tag),
    .rob_rtag1(rob_rtag1), .rob_rtag2(rob_rtag2),
    .rob_rready1(rob_rready1), .rob_rready2(rob_rready2),
    .rob_rdata1(rob_rdata1), .rob_rdata2(rob_rdata2),
    .cdb_data(cdb_data), .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_tag(commit_tag), .rs_is_full(rs_is_full),
    .rs_dest(rs_dest), .rs_data(rs_data)
  );

  assign rf_rdata1   = rf_mem[rf_raddr1];
  assign rf_rdata2   = rf_mem[rf_raddr2];
  assign rob_rready1 = rob_rdy_mem[rob_rtag1];
  assign rob_rready2 = rob_rdy_mem[rob_rtag2];
  assign rob_rdata1  = rob_val_mem[rob_rtag1];
  assign rob_rdata2  = rob_val_mem[rob_rtag2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [75:0] act, input logic [75:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [75:0] pk(input logic [3:0] op, input logic [5:0] tag,
                                     input logic v1, input logic [31:0] o1,
                                     input logic v2, input logic [31:0] o2);
    return {op, tag, v1, o1, v2, o2};
  endfunction

  // Send one instruction (must be accepted) and step into its rs_dest cycle.
  task automatic dec(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic ui, input logic [31:0] imm,
                     input logic [5:0] tag);
    dec_valid = 1'b1; dec_aluop = op; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2;
    dec_use_imm = ui; dec_imm = imm; rob_alloc_tag = tag;
    #1;
    chk("dec_ready", {75'd0, dec_ready}, 76'd1);
    chk("rob_alloc", {75'd0, rob_alloc}, 76'd1);
    tick();
    dec_valid = 1'b0;
    chk("rs_dest_pulse", {75'd0, rs_dest}, 76'd1);
  endtask

  // Forced bubble cycle after a send.
  task automatic gap();
    tick();
    chk("rs_dest_low", {75'd0, rs_dest}, 76'd0);
  endtask

  // Reference: operand value per the source priority rules, using ownership map.
  function automatic logic [32:0] ref_src(input logic [4:0] r);
    int own = ref_owner[r];
    if (r == 5'd0)                          return {1'b1, 32'd0};
    if (own == 0)                           return {1'b1, rf_mem[r]};
    if (int'(cdb_data[37:32]) == own)       return {1'b1, cdb_data[31:0]};
    if (rob_rdy_mem[own])                   return {1'b1, rob_val_mem[own]};
    return {1'b0, 32'(own)};
  endfunction

  // Reference: late CDB capture on a pending operand during the write cycle.
  function automatic logic [75:0] ref_fwd(input logic [75:0] p);
    logic [75:0] q = p;
    int ct = int'(cdb_data[37:32]);
    if (ct != 0) begin
      if (!p[65] && int'(p[38:33]) == ct) begin q[65] = 1'b1; q[64:33] = cdb_data[31:0]; end
      if (!p[32] && int'(p[5:0]) == ct)   begin q[32] = 1'b1; q[31:0]  = cdb_data[31:0]; end
    end
    return q;
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs1, rs2;
    logic        ui;
    logic [31:0] imm;
    logic [5:0]  tag;
    logic [75:0] exp;
  } vec_t;

  vec_t        vt [5];
  logic        exp_dest, exp_ready, acc;
  logic [75:0] exp_pkt;
  logic [32:0] s1, s2;

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b0; dec_valid = 1'b0; dec_aluop = '0; dec_rd = '0; dec_rs1 = '0;
    dec_rs2 = '0; dec_use_imm = 1'b0; dec_imm = '0; rob_full = 1'b0;
    rob_alloc_tag = 6'd1; cdb_data = '0; commit_valid = 1'b0; commit_rd = '0;
    commit_tag = '0; rs_is_full = 1'b0;
    for (int i = 0; i < 32; i++) begin rf_mem[i] = 32'(100 + i); ref_owner[i] = 0; end
    rf_mem[1] = 32'd7; rf_mem[2] = 32'd9;
    for (int i = 0; i < 64; i++) begin rob_rdy_mem[i] = 1'b0; rob_val_mem[i] = 32'(1000 + i); end

    vt[0] = '{4'h1, 5'd3,  5'd4,  1'b0, 32'd0,        6'd3,  pk(4'h1, 6'd3,  1'b1, 32'd103, 1'b1, 32'd104)};
    vt[1] = '{4'h2, 5'd0,  5'd31, 1'b0, 32'd0,        6'd7,  pk(4'h2, 6'd7,  1'b1, 32'd0,   1'b1, 32'd131)};
    vt[2] = '{4'hF, 5'd5,  5'd0,  1'b1, 32'hFFFFFFFC, 6'd63, pk(4'hF, 6'd63, 1'b1, 32'd105, 1'b1, 32'hFFFFFFFC)};
    vt[3] = '{4'h8, 5'd0,  5'd0,  1'b0, 32'd0,        6'd1,  pk(4'h8, 6'd1,  1'b1, 32'd0,   1'b1, 32'd0)};
    vt[4] = '{4'h3, 5'd31, 5'd30, 1'b1, 32'd5,        6'd2,  pk(4'h3, 6'd2,  1'b1, 32'd131, 1'b1, 32'd5)};

    // Reset state
    tick(); tick();
    chk("reset_rs_dest",   {75'd0, rs_dest},   76'd0);
    chk("reset_rs_data",   rs_data,            76'd0);
    chk("reset_dec_ready", {75'd0, dec_ready}, 76'd0);
    reset = 1'b1;
    tick();

    // Table: rd=0 sends leave the status table clean
    for (int i = 0; i < 5; i++) begin
      dec(vt[i].op, 5'd0, vt[i].rs1, vt[i].rs2, vt[i].ui, vt[i].imm, vt[i].tag);
      chk($sformatf("table_%0d", i), rs_data, vt[i].exp);
      gap();
    end

    // x5 = x1 + x2, tag 3
    dec(4'h0, 5'd5, 5'd1, 5'd2, 1'b0, 32'd0, 6'd3);
    chk("basic_add", rs_data, pk(4'h0, 6'd3, 1'b1, 32'd7, 1'b1, 32'd9));
    gap();
    dec_rs1 = 5'd5; #1;
    chk("rtag_x5", {70'd0, rob_rtag1}, 76'd3);

    // RAW: x6 = x5 + x1, producer pending
    dec(4'h0, 5'd6, 5'd5, 5'd1, 1'b0, 32'd0, 6'd4);
    chk("raw_pending", rs_data, pk(4'h0, 6'd4, 1'b0, 32'd3, 1'b1, 32'd7));
    gap();
    dec_rs1 = 5'd6; #1;
    chk("rtag_x6", {70'd0, rob_rtag1}, 76'd4);

    // CDB bypass while resolving
    cdb_data = {6'd3, 32'd42};
    dec(4'h0, 5'd7, 5'd5, 5'd1, 1'b0, 32'd0, 6'd5);
    chk("cdb_resolve", rs_data, pk(4'h0, 6'd5, 1'b1, 32'd42, 1'b1, 32'd7));
    cdb_data = '0;
    gap();

    // CDB arriving in the rs_dest cycle
    dec(4'h0, 5'd8, 5'd5, 5'd1, 1'b0, 32'd0, 6'd9);
    chk("cdb_late_idle", rs_data, pk(4'h0, 6'd9, 1'b0, 32'd3, 1'b1, 32'd7));
    cdb_data = {6'd3, 32'd42}; #1;
    chk("cdb_late_fwd", rs_data, pk(4'h0, 6'd9, 1'b1, 32'd42, 1'b1, 32'd7));
    cdb_data = '0;
    gap();

    // ROB already holds the result
    rob_rdy_mem[3] = 1'b1; rob_val_mem[3] = 32'd55;
    dec(4'h0, 5'd0, 5'd1, 5'd5, 1'b0, 32'd0, 6'd10);
    chk("rob_ready", rs_data, pk(4'h0, 6'd10, 1'b1, 32'd7, 1'b1, 32'd55));
    rob_rdy_mem[3] = 1'b0;
    gap();

    // Commit ownership: x5 rewritten with tag 8, stale commit ignored
    dec(4'h0, 5'd5, 5'd0, 5'd0, 1'b0, 32'd0, 6'd8);
    gap();
    commit_valid = 1'b1; commit_rd = 5'd5; commit_tag = 6'd3;
    tick();
    commit_valid = 1'b0;
    dec_rs1 = 5'd5; #1;
    chk("stale_commit_rtag", {70'd0, rob_rtag1}, 76'd8);
    dec(4'h0, 5'd0, 5'd5, 5'd0, 1'b0, 32'd0, 6'd11);
    chk("stale_commit_busy", rs_data, pk(4'h0, 6'd11, 1'b0, 32'd8, 1'b1, 32'd0));
    gap();
    commit_valid = 1'b1; commit_rd = 5'd5; commit_tag = 6'd8;
    tick();
    commit_valid = 1'b0;
    dec(4'h0, 5'd0, 5'd5, 5'd0, 1'b0, 32'd0, 6'd12);
    chk("commit_frees", rs_data, pk(4'h0, 6'd12, 1'b1, 32'd105, 1'b1, 32'd0));
    gap();

    // Backpressure
    dec_valid = 1'b1; dec_rd = 5'd9; dec_rs1 = 5'd1; dec_rs2 = 5'd2; rob_alloc_tag = 6'd13;
    rs_is_full = 1'b1; #1;
    chk("rsfull_ready", {75'd0, dec_ready}, 76'd0);
    chk("rsfull_alloc", {75'd0, rob_alloc}, 76'd0);
    tick();
    chk("rsfull_dest", {75'd0, rs_dest}, 76'd0);
    rs_is_full = 1'b0; rob_full = 1'b1; #1;
    chk("robfull_ready", {75'd0, dec_ready}, 76'd0);
    chk("robfull_alloc", {75'd0, rob_alloc}, 76'd0);
    tick();
    chk("robfull_dest", {75'd0, rs_dest}, 76'd0);
    rob_full = 1'b0; dec_valid = 1'b0;
    dec(4'h0, 5'd0, 5'd9, 5'd0, 1'b0, 32'd0, 6'd14);
    chk("bp_table_unchanged", rs_data, pk(4'h0, 6'd14, 1'b1, 32'd109, 1'b1, 32'd0));
    gap();

    // Back-to-back with dec_valid held: ready 1,0,1
    dec_valid = 1'b1; dec_rd = 5'd0; dec_rs1 = 5'd1; dec_rs2 = 5'd2; rob_alloc_tag = 6'd15;
    #1;
    chk("b2b_ready0", {75'd0, dec_ready}, 76'd1);
    tick();
    chk("b2b_dest1", {75'd0, rs_dest},   76'd1);
    chk("b2b_ready1", {75'd0, dec_ready}, 76'd0);
    chk("b2b_alloc1", {75'd0, rob_alloc}, 76'd0);
    tick();
    chk("b2b_dest2", {75'd0, rs_dest},   76'd0);
    chk("b2b_ready2", {75'd0, dec_ready}, 76'd1);
    tick();
    chk("b2b_dest3", {75'd0, rs_dest},   76'd1);
    dec_valid = 1'b0;
    gap();

    // Accept and commit to the same rd; self-referencing source reads old owner
    dec(4'h0, 5'd10, 5'd0, 5'd0, 1'b0, 32'd0, 6'd20);
    gap();
    commit_valid = 1'b1; commit_rd = 5'd10; commit_tag = 6'd20;
    dec(4'h0, 5'd10, 5'd10, 5'd0, 1'b0, 32'd0, 6'd21);
    commit_valid = 1'b0;
    chk("self_src_old_tag", rs_data, pk(4'h0, 6'd21, 1'b0, 32'd20, 1'b1, 32'd0));
    gap();
    dec_rs1 = 5'd10; #1;
    chk("accept_wins_rtag", {70'd0, rob_rtag1}, 76'd21);
    dec(4'h0, 5'd0, 5'd10, 5'd0, 1'b0, 32'd0, 6'd22);
    chk("accept_wins_busy", rs_data, pk(4'h0, 6'd22, 1'b0, 32'd21, 1'b1, 32'd0));
    gap();

    // Reset in the rs_dest cycle
    dec(4'h0, 5'd11, 5'd1, 5'd2, 1'b0, 32'd0, 6'd23);
    reset = 1'b0;
    tick();
    chk("midreset_dest", {75'd0, rs_dest}, 76'd0);
    chk("midreset_data", rs_data, 76'd0);
    reset = 1'b1;
    tick();
    dec(4'h0, 5'd0, 5'd11, 5'd5, 1'b0, 32'd0, 6'd24);
    chk("midreset_table", rs_data, pk(4'h0, 6'd24, 1'b1, 32'd111, 1'b1, 32'd105));
    gap();

    // Randomized traffic against the ownership model
    reset = 1'b0; tick(); reset = 1'b1;
    for (int i = 0; i < 32; i++) begin rf_mem[i] = $urandom; ref_owner[i] = 0; end
    for (int i = 0; i < 64; i++) begin rob_rdy_mem[i] = 1'($urandom_range(0, 1)); rob_val_mem[i] = $urandom; end
    tick();
    exp_dest = 1'b0; exp_pkt = '0;
    for (int n = 0; n < 3000; n++) begin
      dec_valid     = ($urandom_range(0, 3) != 0);
      dec_aluop     = 4'($urandom_range(0, 15));
      dec_rd        = 5'($urandom_range(0, 7));
      dec_rs1       = 5'($urandom_range(0, 7));
      dec_rs2       = 5'($urandom_range(0, 7));
      dec_use_imm   = ($urandom_range(0, 3) == 0);
      dec_imm       = $urandom;
      rob_alloc_tag = 6'($urandom_range(1, 63));
      rs_is_full    = ($urandom_range(0, 5) == 0);
      rob_full      = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       cdb_data = {6'($urandom_range(1, 63)), $urandom};
        1:       cdb_data = {6'(ref_owner[$urandom_range(0, 7)]), $urandom};
        default: cdb_data = '0;
      endcase
      commit_valid = ($urandom_range(0, 1) == 1);
      commit_rd    = 5'($urandom_range(0, 7));
      commit_tag   = ($urandom_range(0, 1) == 1) ? 6'(ref_owner[commit_rd]) : 6'($urandom_range(1, 63));
      if ($urandom_range(0, 7) == 0) begin
        int t = $urandom_range(1, 63);
        rob_rdy_mem[t] = ~rob_rdy_mem[t];
      end
      #1;
      chk("rnd_rs_dest", {75'd0, rs_dest}, {75'd0, exp_dest});
      if (exp_dest) chk("rnd_rs_data", rs_data, ref_fwd(exp_pkt));
      exp_ready = !rs_is_full && !rob_full && !exp_dest;
      chk("rnd_dec_ready", {75'd0, dec_ready}, {75'd0, exp_ready});
      acc = dec_valid && exp_ready;
      chk("rnd_rob_alloc", {75'd0, rob_alloc}, {75'd0, acc});
      if (ref_owner[dec_rs1] != 0) chk("rnd_rtag1", {70'd0, rob_rtag1}, 76'(ref_owner[dec_rs1]));
      if (ref_owner[dec_rs2] != 0) chk("rnd_rtag2", {70'd0, rob_rtag2}, 76'(ref_owner[dec_rs2]));
      if (acc) begin
        s1 = ref_src(dec_rs1);
        s2 = dec_use_imm ? {1'b1, dec_imm} : ref_src(dec_rs2);
        exp_pkt = {dec_aluop, rob_alloc_tag, s1, s2};
      end
      if (commit_valid && ref_owner[commit_rd] != 0 && ref_owner[commit_rd] == int'(commit_tag))
        ref_owner[commit_rd] = 0;
      if (acc && dec_rd != 5'd0) ref_owner[dec_rd] = int'(rob_alloc_tag);
      exp_dest = acc;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
